// File: rtl/seq_detector_param.sv
// Programmable serial sequence detector. It compares a shift history of
// accepted bits against a loadable pattern, length and don't-care mask.
// It raises a one-cycle match pulse and keeps a saturating match counter.
module seq_detector_param #(
    parameter int unsigned                 MAX_LEN         = 8,
    parameter int unsigned                 LEN_W           = 4,
    parameter int unsigned                 CNT_W           = 8,
    parameter logic [MAX_LEN-1:0]          DEFAULT_PATTERN = MAX_LEN'(8'b0000_1011),
    parameter int unsigned                 DEFAULT_LEN     = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               sequence_in,
    input  logic               in_valid,
    input  logic               pattern_load,
    input  logic [MAX_LEN-1:0] pattern_in,
    input  logic [LEN_W-1:0]   len_in,
    input  logic [MAX_LEN-1:0] mask_in,
    input  logic               overlap_en,
    input  logic               count_clr,
    output logic               detector_out,
    output logic [CNT_W-1:0]   match_count,
    output logic [LEN_W-1:0]   fill
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_DEF = LEN_W'(DEFAULT_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [MAX_LEN-1:0] r_pattern;
    logic [MAX_LEN-1:0] r_mask;
    logic [LEN_W-1:0]   r_len;
    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic               r_det;
    logic [CNT_W-1:0]   r_count;

    logic [MAX_LEN-1:0] w_hist_next;
    logic [LEN_W-1:0]   w_fill_next;
    logic [MAX_LEN-1:0] w_lenmask;
    logic [LEN_W-1:0]   w_len_load;
    logic               w_match;

    // Next history/fill, active-length mask and the match decision for this cycle
    always_comb begin
        w_hist_next = {r_hist[MAX_LEN-2:0], sequence_in};
        w_fill_next = (r_fill >= r_len) ? r_len : r_fill + LEN_W'(1);
        w_lenmask   = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_lenmask[i] = (LEN_W'(i) < r_len);
        end
        w_len_load  = ((len_in == '0) || (len_in > LEN_MAX)) ? LEN_MAX : len_in;
        w_match     = in_valid && !pattern_load && (w_fill_next == r_len) &&
                      (((w_hist_next ^ r_pattern) & r_mask & w_lenmask) == '0);
    end

    // Programmable pattern, mask and clamped length
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pattern <= DEFAULT_PATTERN;
            r_mask    <= '1;
            r_len     <= LEN_DEF;
        end else if (pattern_load) begin
            r_pattern <= pattern_in;
            r_mask    <= mask_in;
            r_len     <= w_len_load;
        end
    end

    // Shift history and window fill; a load restarts the window, a gap holds it
    always_ff @(posedge clock) begin
        if (reset || pattern_load) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (in_valid) begin
            r_hist <= w_hist_next;
            r_fill <= (w_match && !overlap_en) ? '0 : w_fill_next;
        end
    end

    // One-cycle match pulse, registered
    always_ff @(posedge clock) begin
        if (reset) begin
            r_det <= 1'b0;
        end else begin
            r_det <= w_match;
        end
    end

    // Saturating match counter; clear beats a coincident match
    always_ff @(posedge clock) begin
        if (reset || count_clr) begin
            r_count <= '0;
        end else if (w_match && (r_count != CNT_MAX)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign detector_out = r_det;
    assign match_count  = r_count;
    assign fill         = r_fill;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed table, hand sequences, random vs. model.
module tb_seq_detector_param;

    localparam int unsigned MAX_LEN = 8;
    localparam int unsigned LEN_W   = 4;
    localparam int unsigned CNT_W   = 2;
    localparam int          CMAX    = (1 << CNT_W) - 1;
    localparam logic [7:0]  DEF_PAT = 8'b0000_1011;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic               sequence_in = 1'b0;
    logic               in_valid = 1'b0;
    logic               pattern_load = 1'b0;
    logic [MAX_LEN-1:0] pattern_in = '0;
    logic [LEN_W-1:0]   len_in = '0;
    logic [MAX_LEN-1:0] mask_in = '0;
    logic               overlap_en = 1'b1;
    logic               count_clr = 1'b0;
    logic               detector_out;
    logic [CNT_W-1:0]   match_count;
    logic [LEN_W-1:0]   fill;

    seq_detector_param #(
        .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W),
        .DEFAULT_PATTERN(DEF_PAT), .DEFAULT_LEN(4)
    ) dut (
        .clock(clock), .reset(reset), .sequence_in(sequence_in), .in_valid(in_valid),
        .pattern_load(pattern_load), .pattern_in(pattern_in), .len_in(len_in),
        .mask_in(mask_in), .overlap_en(overlap_en), .count_clr(count_clr),
        .detector_out(detector_out), .match_count(match_count), .fill(fill)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: list of accepted bits plus count of fresh bits in window
    bit         m_q[$];
    int         m_since;
    int         m_len;
    logic [7:0] m_pat;
    logic [7:0] m_mask;
    bit         m_det;
    int         m_cnt;

    function automatic bit pat_ok();
        for (int i = 0; i < m_len; i++) begin
            if (m_mask[i] && (m_q[m_q.size()-1-i] != m_pat[i])) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_step(input bit rst, input bit valid, input bit din, input bit load,
                              input logic [7:0] pat, input logic [3:0] len, input logic [7:0] mask,
                              input bit ov, input bit clr);
        if (rst) begin
            m_q.delete(); m_since = 0; m_det = 0; m_cnt = 0;
            m_pat = DEF_PAT; m_len = 4; m_mask = 8'hFF;
        end else begin
            m_det = 0;
            if (load) begin
                m_pat = pat; m_mask = mask;
                m_len = (len == 0 || len > MAX_LEN) ? MAX_LEN : int'(len);
                m_q.delete(); m_since = 0;
            end else if (valid) begin
                m_q.push_back(din);
                if (m_q.size() > MAX_LEN) void'(m_q.pop_front());
                m_since = (m_since + 1 > m_len) ? m_len : m_since + 1;
                if (m_since == m_len && pat_ok()) begin
                    m_det = 1;
                    if (!ov) m_since = 0;
                end
            end
            if (clr) m_cnt = 0;
            else if (m_det && m_cnt < CMAX) m_cnt++;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive at negedge, model follows the edge, outputs sampled 1 after it
    task automatic cyc(input bit rst, input bit valid, input bit din, input bit load,
                       input logic [7:0] pat, input logic [3:0] len, input logic [7:0] mask,
                       input bit ov, input bit clr);
        @(negedge clock);
        reset = rst; in_valid = valid; sequence_in = din; pattern_load = load;
        pattern_in = pat; len_in = len; mask_in = mask; overlap_en = ov; count_clr = clr;
        @(posedge clock);
        model_step(rst, valid, din, load, pat, len, mask, ov, clr);
        #1;
    endtask

    task automatic acc(input bit din, input bit ov);
        cyc(0, 1, din, 0, 8'h00, 4'd0, 8'h00, ov, 0);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 8'h00, 4'd0, 8'h00, 1, 0);
    endtask

    task automatic do_load(input logic [7:0] pat, input logic [3:0] len, input logic [7:0] mask,
                           input bit valid, input bit clr);
        cyc(0, valid, 1, 1, pat, len, mask, 1, clr);
    endtask

    typedef struct {
        bit rst; bit valid; bit din; bit ov;
        int exp_det; int exp_fill; int exp_cnt;
    } vec_t;

    vec_t tbl[17];

    initial begin
        // Overlap stream 1011011, then non-overlap stream, then an idle cycle
        tbl[0]  = '{1, 0, 0, 1, 0, 0, 0};
        tbl[1]  = '{0, 1, 1, 1, 0, 1, 0};
        tbl[2]  = '{0, 1, 0, 1, 0, 2, 0};
        tbl[3]  = '{0, 1, 1, 1, 0, 3, 0};
        tbl[4]  = '{0, 1, 1, 1, 1, 4, 1};
        tbl[5]  = '{0, 1, 0, 1, 0, 4, 1};
        tbl[6]  = '{0, 1, 1, 1, 0, 4, 1};
        tbl[7]  = '{0, 1, 1, 1, 1, 4, 2};
        tbl[8]  = '{1, 0, 0, 0, 0, 0, 0};
        tbl[9]  = '{0, 1, 1, 0, 0, 1, 0};
        tbl[10] = '{0, 1, 0, 0, 0, 2, 0};
        tbl[11] = '{0, 1, 1, 0, 0, 3, 0};
        tbl[12] = '{0, 1, 1, 0, 1, 0, 1};
        tbl[13] = '{0, 1, 0, 0, 0, 1, 1};
        tbl[14] = '{0, 1, 1, 0, 0, 2, 1};
        tbl[15] = '{0, 1, 1, 0, 0, 3, 1};
        tbl[16] = '{0, 0, 0, 1, 0, 3, 1};

        for (int k = 0; k < 17; k++) begin
            cyc(tbl[k].rst, tbl[k].valid, tbl[k].din, 0, 8'h00, 4'd0, 8'h00, tbl[k].ov, 0);
            chk($sformatf("tbl%0d_det", k), int'(detector_out), tbl[k].exp_det);
            chk($sformatf("tbl%0d_fill", k), int'(fill), tbl[k].exp_fill);
            chk($sformatf("tbl%0d_cnt", k), int'(match_count), tbl[k].exp_cnt);
        end

        // Gaps of three idle cycles between bits keep the partial sequence
        cyc(1, 0, 0, 0, 8'h00, 4'd0, 8'h00, 1, 0);
        begin
            bit gbits[4];
            gbits[0] = 1; gbits[1] = 0; gbits[2] = 1; gbits[3] = 1;
            for (int b = 0; b < 4; b++) begin
                acc(gbits[b], 1);
                chk($sformatf("gap_acc%0d_det", b), int'(detector_out), (b == 3) ? 1 : 0);
                for (int g = 0; g < 3; g++) begin
                    idle();
                    chk($sformatf("gap_idle%0d_%0d_det", b, g), int'(detector_out), 0);
                end
            end
            chk("gap_fill", int'(fill), 4);
            chk("gap_cnt", int'(match_count), 1);
        end

        // Masked 3-bit pattern: middle bit is don't care
        do_load(8'b110, 4'd3, 8'b101, 0, 0);
        chk("ld3_fill", int'(fill), 0);
        acc(1, 1); chk("ld3_b1_det", int'(detector_out), 0);
        acc(0, 1); chk("ld3_b2_det", int'(detector_out), 0);
        acc(0, 1); chk("ld3_b3_det", int'(detector_out), 1);
        chk("ld3_b3_fill", int'(fill), 3);

        // Length 0 clamps to MAX_LEN; all-zero mask matches once the window is full
        do_load(8'h00, 4'd0, 8'h00, 0, 0);
        for (int b = 0; b < 7; b++) begin
            acc(b[0], 1);
            chk($sformatf("len0_b%0d_det", b), int'(detector_out), 0);
        end
        chk("len0_fill7", int'(fill), 7);
        acc(1, 1); chk("len0_b8_det", int'(detector_out), 1);
        chk("len0_fill8", int'(fill), 8);
        acc(0, 1); chk("len0_b9_det", int'(detector_out), 1);

        // Counter saturation at 3, then clear coinciding with a match
        do_load(8'h01, 4'd1, 8'h01, 0, 1);
        chk("sat_clr_cnt", int'(match_count), 0);
        for (int b = 1; b <= 5; b++) begin
            acc(1, 1);
            chk($sformatf("sat_%0d_det", b), int'(detector_out), 1);
            chk($sformatf("sat_%0d_cnt", b), int'(match_count), (b > 3) ? 3 : b);
        end
        cyc(0, 1, 1, 0, 8'h00, 4'd0, 8'h00, 1, 1);
        chk("sat_clr_det", int'(detector_out), 1);
        chk("sat_clr_cnt2", int'(match_count), 0);

        // Reset mid-sequence discards history; load with a bit discards the bit
        cyc(1, 0, 0, 0, 8'h00, 4'd0, 8'h00, 1, 0);
        acc(1, 1); acc(0, 1); acc(1, 1);
        chk("mid_fill3", int'(fill), 3);
        cyc(1, 0, 0, 0, 8'h00, 4'd0, 8'h00, 1, 0);
        chk("mid_rst_fill", int'(fill), 0);
        acc(1, 1);
        chk("mid_b1_det", int'(detector_out), 0);
        chk("mid_b1_fill", int'(fill), 1);
        acc(0, 1); acc(1, 1); acc(1, 1);
        chk("mid_match_det", int'(detector_out), 1);
        chk("mid_match_cnt", int'(match_count), 1);
        do_load(DEF_PAT, 4'd4, 8'hFF, 1, 0);
        chk("ldv_fill", int'(fill), 0);
        chk("ldv_det", int'(detector_out), 0);
        chk("ldv_cnt", int'(match_count), 1);

        // Random traffic against the reference model
        begin
            bit ov;
            ov = 1;
            for (int c = 0; c < 3000; c++) begin
                bit r, v, d, l, cl;
                logic [7:0] p, m;
                logic [3:0] ln;
                r  = ($urandom_range(0, 199) == 0);
                l  = ($urandom_range(0, 29) == 0);
                v  = ($urandom_range(0, 9) < 7);
                d  = 1'($urandom);
                cl = ($urandom_range(0, 39) == 0);
                p  = 8'($urandom);
                m  = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
                ln = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                  : 4'($urandom_range(1, 4));
                if ($urandom_range(0, 15) == 0) ov = ~ov;
                cyc(r, v, d, l, p, ln, m, ov, cl);
                chk("rnd_det", int'(detector_out), int'(m_det));
                chk("rnd_cnt", int'(match_count), m_cnt);
                chk("rnd_fill", int'(fill), (m_since > m_len) ? m_len : m_since);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised, run-time programmable serial sequence detector. It is the successor to the fixed 4-bit pattern FSM detector. It accepts one qualified bit per cycle and compares a shift history against a loadable pattern. Pattern length, don't-care mask and overlap/non-overlap mode are all programmable. It raises a one-cycle match pulse and keeps a saturating match count. It sits on the serial input path ahead of the frame/command decoders.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
LEN_W, 4, width of length fields; must hold the value MAX_LEN
CNT_W, 8, width of match counter
DEFAULT_PATTERN, 8'b0000_1011, pattern after reset (MAX_LEN bits; bit 0 = most recent bit)
DEFAULT_LEN, 4, pattern length after reset

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
sequence_in  in  1  serial data bit
in_valid  in  1  sequence_in is sampled only when high
pattern_load  in  1  latch pattern_in/len_in/mask_in this cycle
pattern_in  in  MAX_LEN  new pattern; bit 0 = last bit of sequence
len_in  in  LEN_W  new length; 0 or >MAX_LEN is clamped to MAX_LEN
mask_in  in  MAX_LEN  per-bit compare enable (1 = compare, 0 = don't care)
overlap_en  in  1  1 = overlapping matches allowed, 0 = non-overlapping
count_clr  in  1  clear match_count
detector_out  out  1  registered one-cycle match pulse
match_count  out  CNT_W  saturating number of matches
fill  out  LEN_W  bits accepted toward current window (saturates at active length)

Behaviour:
- Reset (synchronous, reset=1 at rising edge):
  - hist=0, fill=0, detector_out=0, match_count=0.
  - pattern=DEFAULT_PATTERN, len=DEFAULT_LEN, mask=all ones.
- Accept cycle (in_valid=1, no load):
  - hist_next = {hist[MAX_LEN-2:0], sequence_in}.
  - fill_next = min(fill+1, len).
- Match condition:
  - fill_next == len, and
  - ((hist_next ^ pattern) & mask & lenmask) == 0, where lenmask = low len bits set.
  - Bits above len are ignored.
- Latency: detector_out=1 on the cycle after the accept cycle that completes the match, high for exactly one cycle. Otherwise detector_out=0.
- Non-accept cycles (in_valid=0): hist and fill are held, detector_out=0. Gaps in in_valid do not break a partial sequence.
- Overlap mode (overlap_en=1): fill stays at len after a match, so the next accept may match again.
- Non-overlap mode (overlap_en=0): fill is cleared to 0 on a match. A new match needs len fresh bits. hist is not cleared.
- overlap_en is sampled each accept cycle. A change takes effect from the next match.
- pattern_load=1:
  - Latches pattern, mask, and clamped len.
  - Clears hist and fill; detector_out=0 next cycle.
  - Takes priority over in_valid; a bit presented in the same cycle is discarded.
  - match_count is unaffected.
- match_count:
  - Increments on each match and saturates at 2^CNT_W-1 (no wrap).
  - count_clr sets it to 0. If count_clr and a match coincide, the clear wins (count=0), but detector_out still pulses.
- Mask all zeros with len=L: every accept with fill_next==L matches.
- Reset mid-sequence: the partial history is discarded and the full len bits are needed again. Reset overrides load, clear and valid.

Test Plan:
- Reset defaults, overlap_en=1, accept 1,0,1,1,0,1,1 on consecutive cycles -> detector_out pulses the cycle after bit 4 and after bit 7; match_count=2.
- Same stream, overlap_en=0 -> single pulse after bit 4; fill=3 after bit 7; match_count=1.
- Default pattern, stream 1,0,1,1 with in_valid low for 3 cycles between each bit -> one pulse, one cycle after the final accept; no pulses during gaps.
- Load pattern_in=8'b110, len_in=3, mask_in=8'b101, then accept 1,0,0 -> match (middle bit don't care). Then load len_in=0 -> len reads as 8, and no match before 8 accepts.
- CNT_W=2, overlap on, pattern 1 len 1, accept 5 ones -> 5 pulses, match_count=3. Assert count_clr together with a 6th one -> count 0, pulse present.
- Accept 1,0,1, then reset=1 for one cycle, then accept 1 -> no pulse, fill=1. Also assert pattern_load with in_valid=1 -> bit discarded, fill=0.
